// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths and capture FSM state encoding for the FIR capture sink
package fir_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - first-word-fall-through FIFO with occupancy count
module fir_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign head_data = mem[rd_ptr];

  // Storage carries no reset: contents are only observable while level says so.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/fir_capture_sink.sv
// rtl/fir_capture_sink.sv - captures a fixed-length frame of FIR output into a FWFT FIFO
module fir_capture_sink
  import fir_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  cap_state_t             state_q;
  cap_state_t             state_d;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   offer;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   last_sample;
  logic                   full;
  logic                   empty;

  // Every offered sample counts toward the frame, stored or dropped.
  assign offer       = (state_q == CAPTURE) && in_valid;
  assign pop         = !empty && out_ready;
  assign push        = offer && (!full || pop);
  assign drop        = offer && full && !pop;
  assign last_sample = offer && (frame_cnt == FRAME_CNT_W'(FRAME_LEN - 1));
  assign out_valid   = !empty;

  fir_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head_data (out_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        busy = 1'b1;
        if (last_sample) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = CAPTURE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arming clears the count; start during CAPTURE must not restart the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (start && (state_q != CAPTURE)) begin
      frame_cnt <= '0;
    end else if (offer) begin
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_capture_sink.sv
// tb/tb_fir_capture_sink.sv - directed self-checking bench for fir_capture_sink
module tb_fir_capture_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        clr_ovf;

  logic        a_out_valid, a_busy, a_done, a_overflow;
  logic [15:0] a_out_data;
  logic [3:0]  a_level;
  logic        b_out_valid, b_busy, b_done, b_overflow;
  logic [15:0] b_out_data;
  logic [3:0]  b_level;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Short frame instance
  fir_capture_sink #(.DATA_W(16), .DEPTH(8), .FRAME_LEN(4)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_data  (a_out_data),
    .level     (a_level),
    .busy      (a_busy),
    .done      (a_done),
    .overflow  (a_overflow),
    .clr_ovf   (clr_ovf)
  );

  // Frame longer than the FIFO
  fir_capture_sink #(.DATA_W(16), .DEPTH(8), .FRAME_LEN(12)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_data  (b_out_data),
    .level     (b_level),
    .busy      (b_busy),
    .done      (b_done),
    .overflow  (b_overflow),
    .clr_ovf   (clr_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    // Reset held with stimulus active
    reset     = 1'b0;
    start     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0055;
    out_ready = 1'b1;
    clr_ovf   = 1'b0;
    repeat (3) cyc();
    check("rst_out_valid", 32'(b_out_valid), 32'd0);
    check("rst_busy",      32'(b_busy),      32'd0);
    check("rst_done",      32'(b_done),      32'd0);
    check("rst_overflow",  32'(b_overflow),  32'd0);
    check("rst_level",     32'(b_level),     32'd0);
    check("rst_a_busy",    32'(a_busy),      32'd0);

    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'(i + 1);
      cyc();
    end
    check("idle_ignore_level", 32'(b_level), 32'd0);
    check("idle_ignore_busy",  32'(b_busy),  32'd0);
    check("idle_ignore_a_lvl", 32'(a_level), 32'd0);

    // Basic frame on the FRAME_LEN=4 instance
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    check("basic_busy", 32'(a_busy), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(3 * i);
      cyc();
      check("basic_valid", 32'(a_out_valid), 32'd1);
      check("basic_data",  32'(a_out_data),  32'(3 * i));
    end
    in_valid = 1'b0;
    check("basic_done", 32'(a_done), 32'd1);
    check("basic_notbusy", 32'(a_busy), 32'd0);
    cyc();
    check("basic_level_end", 32'(a_level), 32'd0);
    check("basic_empty_end", 32'(a_out_valid), 32'd0);

    // Overflow on the FRAME_LEN=12 instance
    do_reset();
    pulse_start();
    for (int i = 1; i <= 12; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      cyc();
    end
    in_valid = 1'b0;
    check("ovf_level", 32'(b_level),    32'd8);
    check("ovf_flag",  32'(b_overflow), 32'd1);
    check("ovf_done",  32'(b_done),     32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("ovf_drain_valid", 32'(b_out_valid), 32'd1);
      check("ovf_drain_data",  32'(b_out_data),  32'(i));
      cyc();
    end
    check("ovf_drained", 32'(b_level), 32'd0);
    check("ovf_sticky",  32'(b_overflow), 32'd1);
    out_ready = 1'b0;
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(b_overflow), 32'd0);

    // Full FIFO with simultaneous pop and push (B back in CAPTURE)
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h20 + i);
      cyc();
    end
    check("full_level", 32'(b_level), 32'd8);
    out_ready = 1'b1;
    in_data   = 16'h00AA;
    cyc();
    in_valid = 1'b0;
    check("fullpop_level", 32'(b_level),    32'd8);
    check("fullpop_ovf",   32'(b_overflow), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      check("fullpop_drain", 32'(b_out_data), (i == 8) ? 32'h00AA : 32'(16'h20 + i));
      cyc();
    end
    check("fullpop_empty", 32'(b_level), 32'd0);

    // Start in CAPTURE ignored: 9 counted so far, 3 more finish the frame
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h300 + i);
      cyc();
      if (i == 1) check("rearm_still_busy", 32'(b_busy), 32'd1);
    end
    check("rearm_done", 32'(b_done), 32'd1);
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (3) cyc();
    in_valid = 1'b0;
    check("done_ignore_level", 32'(b_level), 32'd0);
    check("done_ignore_done",  32'(b_done),  32'd1);
    out_ready = 1'b1;
    pulse_start();
    for (int i = 1; i <= 12; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h400 + i);
      cyc();
      if (i == 11) check("restart_busy_11", 32'(b_busy), 32'd1);
    end
    in_valid = 1'b0;
    check("restart_done_12", 32'(b_done), 32'd1);

    // Asynchronous reset mid-frame discards buffered samples
    do_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      cyc();
    end
    in_valid = 1'b0;
    check("midrst_pre_level", 32'(b_level), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("midrst_level", 32'(b_level),     32'd0);
    check("midrst_valid", 32'(b_out_valid), 32'd0);
    check("midrst_busy",  32'(b_busy),      32'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // Pointer wrap: alternating push and pop across two frames
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      if (i == 12) begin
        check("wrap_frame_done", 32'(b_done), 32'd1);
        pulse_start();
      end
      in_valid  = 1'b1;
      out_ready = 1'b0;
      in_data   = 16'(16'h1000 + i);
      cyc();
      check("wrap_level_push", 32'(b_level),    32'd1);
      check("wrap_data",       32'(b_out_data), 32'(16'h1000 + i));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc();
      check("wrap_level_pop", 32'(b_level), 32'd0);
    end
    check("wrap_no_ovf", 32'(b_overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
